// File: rtl/unary_expander.sv
// unary_expander: turns a ones-count into a DW-bit thermometer vector (bits 0..k-1 set)
// streamed LSB chunk first as DW/CW chunks over a valid/ready handshake.
module unary_expander #(
    parameter  int DW   = 32,
    parameter  int CW   = 8,
    localparam int NCH  = DW / CW,
    localparam int IW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNTW = $clog2(DW + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [CNTW-1:0] cnt_i,
    input  logic            cnt_valid_i,
    output logic            cnt_ready_o,
    output logic [CW-1:0]   chunk_o,
    output logic            chunk_valid_o,
    input  logic            chunk_ready_i,
    output logic            chunk_last_o,
    output logic [IW-1:0]   chunk_idx_o
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [IW-1:0]   idx_q;
    logic            ready_q;
    logic            last_idx;
    logic [CW-1:0]   chunk_d;

    assign cnt_d    = (cnt_i > CNTW'(DW)) ? CNTW'(DW) : cnt_i;
    assign last_idx = (idx_q == IW'(NCH - 1));

    // Ready is registered so it stays low for the whole reset and rises one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cnt_valid_i && ready_q) begin
                        cnt_q   <= cnt_d;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (chunk_ready_i) begin
                        if (last_idx) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Bit positions are compared at CNTW bits, so k = DW never overflows.
    always_comb begin
        chunk_d = '0;
        for (int unsigned b = 0; b < CW; b++) begin
            chunk_d[b] = (CNTW'(idx_q) * CNTW'(CW) + CNTW'(b)) < cnt_q;
        end
    end

    assign cnt_ready_o   = ready_q;
    assign chunk_o       = chunk_d;
    assign chunk_valid_o = (state_q == EMIT);
    assign chunk_last_o  = (state_q == EMIT) && last_idx;
    assign chunk_idx_o   = idx_q;

endmodule

// File: tb/tb_unary_expander.sv
// Self-checking bench for unary_expander (DW=32, CW=8): expected chunks are queued at
// accept time from a thermometer-vector model and compared by an independent monitor.
module tb_unary_expander;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NCH = DW / CW;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] cnt_i = '0;
    logic       cnt_valid_i = 1'b0;
    logic       cnt_ready_o;
    logic [7:0] chunk_o;
    logic       chunk_valid_o;
    logic       chunk_ready_i;
    logic       chunk_last_o;
    logic [1:0] chunk_idx_o;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
        int         pop;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   bp_mode = 1;

    unary_expander #(.DW(DW), .CW(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cnt_i        (cnt_i),
        .cnt_valid_i  (cnt_valid_i),
        .cnt_ready_o  (cnt_ready_o),
        .chunk_o      (chunk_o),
        .chunk_valid_o(chunk_valid_o),
        .chunk_ready_i(chunk_ready_i),
        .chunk_last_o (chunk_last_o),
        .chunk_idx_o  (chunk_idx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: k ones from bit 0 upward, saturated to DW, cut into CW-bit chunks.
    function automatic void push_vec(input int k);
        int          sat;
        logic [63:0] v;
        exp_t        e;
        sat = (k > DW) ? DW : k;
        v = (64'd1 << sat) - 64'd1;
        for (int i = 0; i < NCH; i++) begin
            e.data = v[i*CW +: CW];
            e.idx  = 2'(i);
            e.last = (i == NCH - 1);
            e.pop  = sat;
            sb.push_back(e);
        end
    endfunction

    // Sole driver of chunk_ready_i: 0 = hold low, 1 = tied high, 2 = random.
    initial begin
        chunk_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: chunk_ready_i = 1'b0;
                1: chunk_ready_i = 1'b1;
                default: chunk_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops on each handshake, checks stability under stall and reassembled popcount.
    initial begin
        logic [31:0] acc;
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic [1:0]  prev_idx;
        logic        prev_last;
        exp_t        e;
        acc = '0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_idx = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                acc = '0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(chunk_valid_o), 64'd1);
                    chk("stall_data", 64'(chunk_o), 64'(prev_data));
                    chk("stall_idx", 64'(chunk_idx_o), 64'(prev_idx));
                    chk("stall_last", 64'(chunk_last_o), 64'(prev_last));
                end
                if (chunk_valid_o && chunk_ready_i) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_chunk", 64'(chunk_o), 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        chk("chunk_data", 64'(chunk_o), 64'(e.data));
                        chk("chunk_idx", 64'(chunk_idx_o), 64'(e.idx));
                        chk("chunk_last", 64'(chunk_last_o), 64'(e.last));
                        acc[int'(chunk_idx_o)*CW +: CW] = chunk_o;
                        if (e.last) begin
                            chk("popcount", 64'($countones(acc)), 64'(e.pop));
                            acc = '0;
                        end
                    end
                end
                prev_stall = chunk_valid_o && !chunk_ready_i;
                prev_data = chunk_o;
                prev_idx = chunk_idx_o;
                prev_last = chunk_last_o;
            end
        end
    end

    task automatic send(input int k, output int acc_cyc);
        int n;
        n = 0;
        cnt_i = 6'(k);
        cnt_valid_i = 1'b1;
        while (1) begin
            @(negedge clk);
            if (cnt_ready_o) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        push_vec(k);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cnt_valid_i = 1'b0;
        chk("latency_valid", 64'(chunk_valid_o), 64'd1);
        chk("busy_ready", 64'(cnt_ready_o), 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("idle_ready", 64'(cnt_ready_o), 64'd1);
        chk("idle_valid", 64'(chunk_valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a1, a2, tmp;
        // Reset values, ready low throughout reset then high one cycle after.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(cnt_ready_o), 64'd0);
        chk("rst_valid", 64'(chunk_valid_o), 64'd0);
        chk("rst_chunk", 64'(chunk_o), 64'd0);
        chk("rst_last", 64'(chunk_last_o), 64'd0);
        chk("rst_idx", 64'(chunk_idx_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(cnt_ready_o), 64'd1);

        // Zero, partial, full and saturating counts with ready tied high.
        bp_mode = 1;
        send(0, tmp);  drain();
        send(11, tmp); drain();
        send(32, tmp); drain();
        send(40, tmp); drain();
        send(63, tmp); drain();

        // Backpressure at idx 1 with an ignored count pulse.
        send(20, tmp);
        @(posedge clk);
        #1;
        bp_mode = 0;
        cnt_i = 6'd3;
        cnt_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_chunk", 64'(chunk_o), 64'hFF);
            chk("bp_idx", 64'(chunk_idx_o), 64'd1);
            chk("bp_ready", 64'(cnt_ready_o), 64'd0);
        end
        @(posedge clk);
        #1;
        cnt_valid_i = 1'b0;
        bp_mode = 1;
        drain();

        // Reset while idx 2 of count 30 is presented.
        send(30, tmp);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_idx", 64'(chunk_idx_o), 64'd2);
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("midrst_valid", 64'(chunk_valid_o), 64'd0);
        chk("midrst_chunk", 64'(chunk_o), 64'd0);
        chk("midrst_idx", 64'(chunk_idx_o), 64'd0);
        chk("midrst_last", 64'(chunk_last_o), 64'd0);
        chk("midrst_ready", 64'(cnt_ready_o), 64'd0);
        send(5, tmp); drain();

        // Back-to-back: second count accepted NCH+1 cycles after the first.
        send(5, a1);
        send(17, a2);
        chk("b2b_gap", 64'(a2 - a1), 64'(NCH + 1));
        drain();

        // Random counts under random backpressure.
        bp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 63)), tmp);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        bp_mode = 1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
